// File: rtl/demux_pipeline.sv
// demux_pipeline: pipelined 1:N demultiplexer built as a tree of registered
// DEMUX_SIZE-way split stages. Every accepted word takes exactly LATENCY
// clocks to reach its lane, so one word can be issued per clock.
//
// Handshake: a word is taken whenever in_valid=1 on a rising edge (there is
// no ready; the block never stalls). Lane k reports delivery with a
// one-cycle out_valid[k] pulse, and out lane k carries the word in that
// same cycle.
//
// Stage s of the tree holds one register set per node that leads to at
// least one real lane (index < OUTPUT_COUNT). Nodes whose subtree contains
// only non-existent lanes are tied to zero instead of being registered, so
// words steered toward them simply vanish.
module demux_pipeline #(
    parameter int WIDTH        = 4,
    parameter int OUTPUT_COUNT = 2,
    parameter int DEMUX_SIZE   = 2,
    parameter int HOLD         = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [$clog2(OUTPUT_COUNT)-1:0] sel,
    input  logic                            in_valid,
    input  logic [WIDTH-1:0]                in,
    output logic [WIDTH*OUTPUT_COUNT-1:0]   out,
    output logic [OUTPUT_COUNT-1:0]         out_valid
);

    // Smallest L >= 1 with ds**L >= oc.
    function automatic int calc_levels(input int oc, input int ds);
        int     l;
        longint span;
        l    = 1;
        span = ds;
        while (span < oc) begin
            span = span * ds;
            l    = l + 1;
        end
        return l;
    endfunction

    function automatic int ipow(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) begin
            r = r * b;
        end
        return r;
    endfunction

    localparam int SB      = $clog2(DEMUX_SIZE);
    localparam int LEVELS  = calc_levels(OUTPUT_COUNT, DEMUX_SIZE);
    localparam int LATENCY = LEVELS;
    localparam int SELW    = LEVELS * SB;
    localparam int MAXN    = ipow(DEMUX_SIZE, LEVELS);

    if (OUTPUT_COUNT < 2) begin : g_bad_count
        $error("demux_pipeline: OUTPUT_COUNT must be >= 2");
    end
    if (DEMUX_SIZE < 2 || (DEMUX_SIZE & (DEMUX_SIZE - 1)) != 0) begin : g_bad_size
        $error("demux_pipeline: DEMUX_SIZE must be a power of two >= 2");
    end

    // Per-stage node views; pruned nodes read as constant zero.
    logic [WIDTH-1:0] data_w [LEVELS][MAXN];
    logic             vld_w  [LEVELS][MAXN];
    logic [SELW-1:0]  sel_w  [LEVELS][MAXN];

    // Out-of-range selects are dropped at the root rather than relying only
    // on pruning, which keeps the discard explicit.
    logic            root_vld;
    logic [SELW-1:0] root_sel;

    assign root_vld = in_valid && (32'(sel) < 32'(OUTPUT_COUNT));
    assign root_sel = SELW'(sel);

    for (genvar s = 0; s < LEVELS; s++) begin : g_stage
        for (genvar j = 0; j < MAXN; j++) begin : g_node
            localparam int SPAN  = ipow(DEMUX_SIZE, LEVELS - 1 - s);
            localparam int NODES = ipow(DEMUX_SIZE, s + 1);
            localparam bit LIVE  = (j < NODES) && (j * SPAN < OUTPUT_COUNT);
            localparam bit LAST  = (s == LEVELS - 1);

            if (LIVE) begin : g_live
                localparam logic [SB-1:0] DIGIT = SB'(j % DEMUX_SIZE);

                logic             par_vld;
                logic [WIDTH-1:0] par_data;
                logic [SELW-1:0]  par_sel;

                if (s == 0) begin : g_root_par
                    assign par_vld  = root_vld;
                    assign par_data = in;
                    assign par_sel  = root_sel;
                end else begin : g_node_par
                    assign par_vld  = vld_w[s-1][j/DEMUX_SIZE];
                    assign par_data = data_w[s-1][j/DEMUX_SIZE];
                    assign par_sel  = sel_w[s-1][j/DEMUX_SIZE];
                end

                logic             vld_d, vld_q;
                logic [WIDTH-1:0] data_d, data_q;
                logic [SELW-1:0]  sel_d, sel_q;

                // Accept the parent's word only when this node is the digit's target.
                always_comb begin
                    vld_d  = par_vld && (par_sel[(LEVELS-1-s)*SB +: SB] == DIGIT);
                    data_d = data_q;
                    sel_d  = sel_q;
                    if (vld_d) begin
                        data_d = par_data;
                        sel_d  = LAST ? '0 : par_sel;
                    end else if (LAST && HOLD == 0) begin
                        data_d = '0;
                    end
                end

                // Node registers; reset flushes anything in flight.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        vld_q  <= 1'b0;
                        data_q <= '0;
                        sel_q  <= '0;
                    end else begin
                        vld_q  <= vld_d;
                        data_q <= data_d;
                        sel_q  <= sel_d;
                    end
                end

                assign vld_w[s][j]  = vld_q;
                assign data_w[s][j] = data_q;
                assign sel_w[s][j]  = sel_q;
            end else begin : g_pruned
                assign vld_w[s][j]  = 1'b0;
                assign data_w[s][j] = '0;
                assign sel_w[s][j]  = '0;
            end
        end
    end

    // The last stage registers are the lanes themselves.
    for (genvar k = 0; k < OUTPUT_COUNT; k++) begin : g_lane
        assign out[k*WIDTH +: WIDTH] = data_w[LEVELS-1][k];
        assign out_valid[k]          = vld_w[LEVELS-1][k];
    end

endmodule

// File: tb/tb_demux_pipeline.sv
// Bench for demux_pipeline: three instances share one input stream
// (radix 2 / hold, radix 4 / hold, radix 2 / zeroing) and are compared every
// cycle against a transaction-level model of the delivery rules.
module tb_demux_pipeline;

    localparam int W    = 4;
    localparam int OC   = 10;
    localparam int NCFG = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid;
    logic [3:0]    sel;
    logic [W-1:0]  in_data;

    logic [W*OC-1:0] out_a, out_b, out_c;
    logic [OC-1:0]   vld_a, vld_b, vld_c;

    demux_pipeline #(.WIDTH(W), .OUTPUT_COUNT(OC), .DEMUX_SIZE(2), .HOLD(1)) dut_a (
        .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in(in_data),
        .out(out_a), .out_valid(vld_a)
    );
    demux_pipeline #(.WIDTH(W), .OUTPUT_COUNT(OC), .DEMUX_SIZE(4), .HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in(in_data),
        .out(out_b), .out_valid(vld_b)
    );
    demux_pipeline #(.WIDTH(W), .OUTPUT_COUNT(OC), .DEMUX_SIZE(2), .HOLD(0)) dut_c (
        .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in(in_data),
        .out(out_c), .out_valid(vld_c)
    );

    // Radix 2 over 10 lanes needs 2**4 >= 10 -> 4 levels; radix 4 needs 4**2 -> 2.
    int lat  [NCFG] = '{4, 2, 4};
    int hold [NCFG] = '{1, 1, 0};

    typedef struct {
        int           t;
        int           lane;
        logic [W-1:0] data;
    } issue_t;

    issue_t       exp_q [$];
    logic [W-1:0] exp_lane [NCFG][OC];
    logic [OC-1:0] exp_vld [NCFG];

    int edge_n   = 0;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W*OC-1:0] pack_lanes(input int c);
        logic [W*OC-1:0] v;
        for (int k = 0; k < OC; k++) begin
            v[k*W +: W] = exp_lane[c][k];
        end
        return v;
    endfunction

    function automatic logic [W*OC-1:0] obs_out(input int c);
        case (c)
            0:       return out_a;
            1:       return out_b;
            default: return out_c;
        endcase
    endfunction

    function automatic logic [OC-1:0] obs_vld(input int c);
        case (c)
            0:       return vld_a;
            1:       return vld_b;
            default: return vld_c;
        endcase
    endfunction

    // Advance the reference model by one rising edge using the inputs it sampled.
    task automatic model_edge();
        edge_n++;
        if (rst) begin
            exp_q.delete();
            for (int c = 0; c < NCFG; c++) begin
                exp_vld[c] = '0;
                for (int k = 0; k < OC; k++) exp_lane[c][k] = '0;
            end
        end else begin
            if (in_valid && int'(sel) < OC) begin
                exp_q.push_back('{t: edge_n, lane: int'(sel), data: in_data});
            end
            for (int c = 0; c < NCFG; c++) begin
                exp_vld[c] = '0;
                if (hold[c] == 0) begin
                    for (int k = 0; k < OC; k++) exp_lane[c][k] = '0;
                end
                foreach (exp_q[i]) begin
                    if (exp_q[i].t + lat[c] - 1 == edge_n) begin
                        exp_lane[c][exp_q[i].lane]  = exp_q[i].data;
                        exp_vld[c][exp_q[i].lane]   = 1'b1;
                    end
                end
            end
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].t + 3 <= edge_n) exp_q.delete(i);
            end
        end
    endtask

    task automatic compare();
        for (int c = 0; c < NCFG; c++) begin
            check($sformatf("vld cfg%0d edge%0d", c, edge_n), 64'(obs_vld(c)), 64'(exp_vld[c]));
            check($sformatf("out cfg%0d edge%0d", c, edge_n), 64'(obs_out(c)), 64'(pack_lanes(c)));
            check($sformatf("onehot cfg%0d edge%0d", c, edge_n),
                  64'($countones(obs_vld(c)) <= 1), 64'(1));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic send(input logic v, input logic [3:0] s, input logic [W-1:0] d);
        in_valid = v;
        sel      = s;
        in_data  = d;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            send(1'b0, 4'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        sel      = '0;
        in_data  = '0;
        cycle();
        cycle();
        rst = 1'b0;

        // Lane sweep, back to back.
        for (int k = 0; k < OC; k++) send(1'b1, 4'(k), W'(k + 1));
        idle(6);

        // Same-lane burst.
        for (int d = 10; d <= 14; d++) send(1'b1, 4'd3, W'(d));
        idle(6);

        // Out-of-range selects, then a normal word.
        send(1'b1, 4'd12, 4'h9);
        send(1'b1, 4'd15, 4'h4);
        idle(8);
        send(1'b1, 4'd2, 4'd7);
        idle(6);

        // Reset while words are in flight; in_valid during reset is ignored.
        send(1'b1, 4'd1, 4'd5);
        send(1'b1, 4'd6, 4'd9);
        idle(1);
        rst = 1'b1;
        send(1'b1, 4'd0, 4'd1);
        rst = 1'b0;
        idle(2);
        send(1'b1, 4'd4, 4'd3);
        idle(6);

        // Lane hold versus zeroing.
        send(1'b1, 4'd2, 4'd6);
        idle(6);

        // Random traffic with occasional reset and invalid selects.
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        end
        rst = 1'b0;
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_pipeline.md
Name: demux_pipeline

Overview:
- Pipelined 1:N demultiplexer. Routes one WIDTH-bit input word to one of OUTPUT_COUNT output lanes through a tree of registered DEMUX_SIZE-way split stages.
- Fixed latency for every selection, so one word is accepted per clock with no back-pressure.
- It is the distribution-side counterpart of mux_pipeline. It fans a single stream out to many consumers in high-speed designs, and each lane carries a valid flag.

Parameters:
- WIDTH, 4, data word width in bits.
- OUTPUT_COUNT, 2, number of output lanes; must be >= 2.
- DEMUX_SIZE, 2, fan-out per tree stage; must be 2**N (2, 4, 8, 16...).
- HOLD, 1. 1 = an idle lane keeps its last delivered word. 0 = an idle lane drives zero.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- sel  input  $clog2(OUTPUT_COUNT)  destination lane index, sampled with in_valid.
- in_valid  input  1  qualifies in/sel this cycle.
- in  input  WIDTH  data word.
- out  output  WIDTH*OUTPUT_COUNT  lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  OUTPUT_COUNT  bit k is a one-cycle pulse when lane k receives a word.

Behaviour:
- Derived constants:
  - SB = log2(DEMUX_SIZE).
  - LEVELS = smallest L with DEMUX_SIZE**L >= OUTPUT_COUNT (minimum 1).
  - LATENCY = LEVELS clocks.
  - Expose LATENCY as a localparam.
- Select handling:
  - sel is zero-extended to LEVELS*SB bits.
  - Stage s (s = 0 at the root) steers on digit [(LEVELS-1-s)*SB +: SB], MSB digit first.
  - The remaining sel digits are pipelined alongside the data so that each stage sees the select of its own word.
- Stage registers:
  - Each stage holds a data register, a valid bit and the residual sel for every node.
  - A node forwards its word to exactly one child and sets only that child's valid bit. The other children's valid bits clear that cycle.
  - Only tree branches that lead to real lanes (< OUTPUT_COUNT) are instantiated. Unused branches are pruned, not registered.
- Timing:
  - in_valid=1 with sel=k at posedge t gives out_valid[k]=1 for exactly one cycle.
  - That pulse is visible after posedge t+LATENCY-1, i.e. sampled at edge t+LATENCY.
  - At the same time, out lane k equals the word sampled at t.
- Throughput:
  - One word per cycle. Back-to-back words to the same or different lanes never collide or drop.
  - Several out_valid bits are never high in the same cycle, because the input is single-issue.
- Invalid select: sel >= OUTPUT_COUNT with in_valid=1 is discarded. No out_valid pulse, and no lane data changes.
- in_valid=0: no lane is updated and no pulse is produced. Data inputs are don't-care.
- Lane data:
  - HOLD=1: a lane's data updates only in the cycle its out_valid pulses, otherwise it holds.
  - HOLD=0: a lane's data equals the delivered word when its out_valid=1, and is 0 otherwise.
- Reset:
  - All valid bits, out_valid, out lanes and internal data registers go to 0 on the first posedge with rst=1.
  - Words in flight at reset are dropped and never emerge.
  - in_valid asserted in the same cycle as rst is ignored.
  - The first word accepted after rst deasserts emerges at the full LATENCY.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- Lane sweep, OUTPUT_COUNT=10, DEMUX_SIZE=2 (LATENCY=4): drive sel=0..9 back-to-back with in=sel+1 and in_valid=1 → out_valid[k] pulses exactly once, 4 clocks after issue, with lane k = k+1. Exactly one out_valid bit is high per cycle.
- Same-lane burst: five consecutive words 0xA,0xB,0xC,0xD,0xE to sel=3 → out_valid[3] high for 5 consecutive cycles, and lane 3 shows A..E in order, 4 clocks after each issue.
- Invalid select: sel=12 and sel=15 with in_valid=1 on OUTPUT_COUNT=10 → no out_valid pulse within 8 cycles, all lanes unchanged. A following valid sel=2, in=7 still arrives correctly.
- Reset mid-flight: issue sel=1/in=5 and sel=6/in=9, then assert rst for 1 cycle two clocks later → no out_valid pulses, all out=0. A post-reset word (sel=4, in=3) arrives after exactly 4 clocks.
- Radix check, DEMUX_SIZE=4, OUTPUT_COUNT=10 (LATENCY=2): sweep sel 0..9 → each lane k receives its word 2 clocks after issue.
- HOLD=0 vs HOLD=1: send in=6 to lane 2, then idle → with HOLD=1 lane 2 stays 6; with HOLD=0 lane 2 reads 6 only in its out_valid cycle and 0 after.
